// File: rtl/snn_conv_quant_if.sv
// Frame-in / result-out handshake bundle for the 3x3 convolution + quantiser.
// master drives pixels and kernel taps; slave returns the quantised results.
interface snn_conv_quant_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] img;
    logic [DATA_W-1:0] ker;
    logic              mode;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, img, ker, mode, input out_valid, out_data);
    modport slave  (input in_valid, img, ker, mode, output out_valid, out_data);
endinterface

// File: rtl/snn_conv_quant.sv
// Frame-buffered 3x3 convolution with optional edge-replicate padding, followed by
// divide-by-QDIV quantisation with saturation; one result per cycle in raster order.
module snn_conv_quant #(
    parameter int IMG_W  = 6,
    parameter int DATA_W = 8,
    parameter int QDIV   = 2295
) (
    input  logic            clk,
    input  logic            rst_n,
    snn_conv_quant_if.slave bus
);
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int POS_W  = $clog2(IMG_W);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 4;
    localparam int DIV_W  = (SUM_W > 32) ? SUM_W : 32;
    localparam logic [DIV_W-1:0] MAXV = {{(DIV_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

    state_t                      r_state, w_next;
    logic [IDX_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            w_waddr;
    logic                        w_wr;
    logic                        r_mode;
    logic                        r_ov;
    logic [DATA_W-1:0]           r_od;
    logic [POS_W-1:0]            r_orow, r_ocol;
    logic [POS_W-1:0]            w_cr, w_cc, w_nm1;
    logic                        w_last;
    logic [NPIX-1:0][DATA_W-1:0] r_img;
    logic [8:0][DATA_W-1:0]      r_ker;
    logic [8:0][PROD_W-1:0]      w_prod;
    logic [SUM_W-1:0]            w_sum;
    logic [DIV_W-1:0]            w_quot;
    logic [DATA_W-1:0]           w_q;

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > IMG_W - 1) return IMG_W - 1;
        return v;
    endfunction

    assign w_wr    = bus.in_valid && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_waddr = (r_state == S_IDLE) ? '0 : r_cnt;

    // Storage is write-only from the load side; it needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_img[w_waddr] <= bus.img;
            if (w_waddr < IDX_W'(9))
                r_ker[4'(w_waddr)] <= bus.ker;
        end
    end

    assign w_nm1  = r_mode ? POS_W'(IMG_W - 1) : POS_W'(IMG_W - 3);
    assign w_last = (r_orow == w_nm1) && (r_ocol == w_nm1);

    // Position of the result being computed this cycle: (0,0) in CALC, else the successor.
    always_comb begin
        w_cr = r_orow;
        w_cc = r_ocol + 1'b1;
        if (r_state == S_CALC) begin
            w_cr = '0;
            w_cc = '0;
        end else if (r_ocol == w_nm1) begin
            w_cr = r_orow + 1'b1;
            w_cc = '0;
        end
    end

    // Window offset equals mode (0 or 1); clamping only ever bites in padded mode.
    for (genvar ti = 0; ti < 3; ti++) begin : g_row
        for (genvar tj = 0; tj < 3; tj++) begin : g_col
            localparam int K = ti * 3 + tj;
            logic [IDX_W-1:0] w_addr;
            assign w_addr = IDX_W'(clampi(int'(w_cr) + ti - int'(r_mode)) * IMG_W
                                 + clampi(int'(w_cc) + tj - int'(r_mode)));
            assign w_prod[K] = PROD_W'(r_ker[K]) * PROD_W'(r_img[w_addr]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++)
            w_sum = w_sum + SUM_W'(w_prod[k]);
    end

    assign w_quot = DIV_W'(w_sum) / DIV_W'(QDIV);
    assign w_q    = (w_quot > MAXV) ? {DATA_W{1'b1}} : w_quot[DATA_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_next = S_LOAD;
            S_LOAD: begin
                if (!bus.in_valid)
                    w_next = S_IDLE;
                else if (r_cnt == IDX_W'(NPIX - 1))
                    w_next = S_CALC;
            end
            S_CALC: w_next = S_OUT;
            S_OUT:  if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_ov    <= 1'b0;
            r_od    <= '0;
            r_orow  <= '0;
            r_ocol  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mode <= bus.mode;
                        r_cnt  <= IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid && r_cnt != IDX_W'(NPIX - 1))
                        r_cnt <= r_cnt + 1'b1;
                    else
                        r_cnt <= '0;
                end
                S_CALC: begin
                    r_ov   <= 1'b1;
                    r_od   <= w_q;
                    r_orow <= '0;
                    r_ocol <= '0;
                end
                S_OUT: begin
                    if (w_last) begin
                        r_ov <= 1'b0;
                        r_od <= '0;
                    end else begin
                        r_od   <= w_q;
                        r_orow <= w_cr;
                        r_ocol <= w_cc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = r_ov;
    assign bus.out_data  = r_od;
endmodule

// File: tb/tb_snn_conv_quant.sv
// Directed bench: table of frames with hand-derived expected results, plus abort,
// reset-in-OUT, back-to-back and ignored-in_valid sequences on 6x6 and 3x3 instances.
module tb_snn_conv_quant;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_conv_quant_if #(.DATA_W(8)) bus6 ();
    snn_conv_quant_if #(.DATA_W(8)) bus3 ();

    snn_conv_quant #(.IMG_W(6), .DATA_W(8), .QDIV(2295)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
    snn_conv_quant #(.IMG_W(3), .DATA_W(8), .QDIV(2295)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // ik: 0 const iv, 1 pixel 9*idx, 2 pixel 7*idx
    // kk: 0 const kv, 1 centre tap 255, 2 top-left tap 255
    // ek: 0 const ec, 1 6(r+1)+(c+1), 2 floor(7(6r+c)/9), 3 clamp(r-1)*6+clamp(c-1)
    typedef struct {
        bit dut;
        bit mode;
        int ik;
        int iv;
        int kk;
        int kv;
        int ek;
        int ec;
        int n;
    } vec_t;

    vec_t tbl[10];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    function automatic int g_ov(input bit d);
        return d ? int'(bus3.out_valid) : int'(bus6.out_valid);
    endfunction

    function automatic int g_od(input bit d);
        return d ? int'(bus3.out_data) : int'(bus6.out_data);
    endfunction

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 5) return 5;
        return v;
    endfunction

    function automatic logic [7:0] pix(input vec_t v, input int p);
        case (v.ik)
            1:       return 8'(9 * p);
            2:       return 8'(7 * p);
            default: return 8'(v.iv);
        endcase
    endfunction

    function automatic logic [7:0] kerv(input vec_t v, input int p);
        if (p >= 9) return 8'($urandom);
        case (v.kk)
            1:       return (p == 4) ? 8'd255 : 8'd0;
            2:       return (p == 0) ? 8'd255 : 8'd0;
            default: return 8'(v.kv);
        endcase
    endfunction

    function automatic int expv(input vec_t v, input int r, input int c);
        case (v.ek)
            1:       return 6 * (r + 1) + (c + 1);
            2:       return (7 * (r * 6 + c)) / 9;
            3:       return clampi(r - 1) * 6 + clampi(c - 1);
            default: return v.ec;
        endcase
    endfunction

    task automatic drv(input bit d, input logic vld, input logic [7:0] im, input logic [7:0] k, input logic m);
        if (d) begin
            bus3.in_valid = vld; bus3.img = im; bus3.ker = k; bus3.mode = m;
        end else begin
            bus6.in_valid = vld; bus6.img = im; bus6.ker = k; bus6.mode = m;
        end
    endtask

    // Leaves the caller #1 into the cycle after the last sample (t+1).
    task automatic send(input vec_t v, input int nsamp, input bit linger);
        for (int p = 0; p < nsamp; p++) begin
            @(posedge clk); #1;
            if (p == 0) check("idle_ov", 0, g_ov(v.dut), 0);
            drv(v.dut, 1'b1, pix(v, p), kerv(v, p), (p == 0) ? v.mode : ~v.mode);
        end
        @(posedge clk); #1;
        drv(v.dut, linger, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    task automatic collect(input vec_t v, input bit trail);
        int side;
        side = (v.dut ? 3 : 6) - (v.mode ? 0 : 2);
        @(negedge clk);
        check("calc_ov", 0, g_ov(v.dut), 0);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            check("out_valid", k, g_ov(v.dut), 1);
            check("out_data", k, g_od(v.dut), expv(v, k / side, k % side));
        end
        if (trail) begin
            @(negedge clk);
            check("end_ov", v.n, g_ov(v.dut), 0);
            check("end_od", v.n, g_od(v.dut), 0);
        end
    endtask

    task automatic watch_quiet(input bit d, input int cycles, input string nm);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (g_ov(d) != 0) seen++;
        end
        check(nm, 0, seen, 0);
    endtask

    initial begin
        //              dut mode ik iv  kk kv  ek ec  n
        tbl[0] = '{1'b0, 1'b0, 0, 255, 0, 255, 0, 255, 16};
        tbl[1] = '{1'b0, 1'b1, 0, 255, 0, 1,   0, 1,   36};
        tbl[2] = '{1'b0, 1'b0, 1, 0,   1, 0,   1, 0,   16};
        tbl[3] = '{1'b0, 1'b1, 2, 0,   1, 0,   2, 0,   36};
        tbl[4] = '{1'b0, 1'b1, 1, 0,   2, 0,   3, 0,   36};
        tbl[5] = '{1'b0, 1'b0, 0, 200, 0, 255, 0, 200, 16};
        tbl[6] = '{1'b0, 1'b1, 0, 100, 0, 1,   0, 0,   36};
        tbl[7] = '{1'b0, 1'b0, 0, 254, 0, 2,   0, 1,   16};
        tbl[8] = '{1'b1, 1'b0, 0, 20,  0, 255, 0, 20,  1};
        tbl[9] = '{1'b1, 1'b1, 0, 100, 0, 255, 0, 100, 9};

        drv(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        drv(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_ov6", 0, g_ov(1'b0), 0);
        check("rst_od6", 0, g_od(1'b0), 0);
        check("rst_ov3", 0, g_ov(1'b1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i], tbl[i].dut ? 9 : 36, 1'b0);
            collect(tbl[i], 1'b1);
            repeat (2) @(negedge clk);
        end

        // Short frame is dropped, next full frame is unaffected
        send(tbl[0], 20, 1'b0);
        watch_quiet(1'b0, 60, "abort_ov");
        send(tbl[0], 36, 1'b0);
        collect(tbl[0], 1'b1);

        // Back-to-back frames on both sizes
        send(tbl[5], 36, 1'b0);
        collect(tbl[5], 1'b0);
        send(tbl[2], 36, 1'b0);
        collect(tbl[2], 1'b1);
        send(tbl[8], 9, 1'b0);
        collect(tbl[8], 1'b0);
        send(tbl[9], 9, 1'b0);
        collect(tbl[9], 1'b1);

        // in_valid held through CALC and early OUT with junk must not disturb results
        send(tbl[5], 36, 1'b1);
        fork
            collect(tbl[5], 1'b1);
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                    bus6.img = 8'($urandom);
                    bus6.ker = 8'($urandom);
                end
                bus6.in_valid = 1'b0;
            end
        join
        watch_quiet(1'b0, 10, "junk_ov");

        // Asynchronous reset in the 5th OUT cycle
        send(tbl[0], 36, 1'b0);
        @(negedge clk);
        check("rst_calc_ov", 0, g_ov(1'b0), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_pre_data", k, g_od(1'b0), 255);
        end
        @(posedge clk); #1;
        check("rst_pre_ov", 0, g_ov(1'b0), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ov", 0, g_ov(1'b0), 0);
        check("rst_async_od", 0, g_od(1'b0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(1'b0, 20, "rst_quiet_ov");
        send(tbl[7], 36, 1'b0);
        collect(tbl[7], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
